// File: rtl/vga_grid_renderer.sv
// Grid cell renderer: queues per-cell colour requests in a small FIFO and rasterises each
// cell, or a full-grid background clear, into a one-pixel-per-clock write stream.
module vga_grid_renderer #(
    parameter int                     COLS        = 12,
    parameter int                     ROWS        = 12,
    parameter int                     CELL_W      = 31,
    parameter int                     CELL_H      = 31,
    parameter int                     PITCH_X     = 33,
    parameter int                     PITCH_Y     = 33,
    parameter int                     X0          = 214,
    parameter int                     Y0          = 32,
    parameter int                     COLOR_DEPTH = 9,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR    = COLOR_DEPTH'(7),
    parameter int                     FIFO_DEPTH  = 4,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    input  logic                   vga_sync,
    input  logic                   clear_req,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [COL_W-1:0]       req_col,
    input  logic [ROW_W-1:0]       req_row,
    input  logic [COLOR_DEPTH-1:0] req_color,
    output logic [9:0]             pix_x,
    output logic [8:0]             pix_y,
    output logic [COLOR_DEPTH-1:0] pix_color,
    output logic                   pix_write,
    output logic                   busy,
    output logic                   done,
    output logic                   req_err
);
    localparam int DX_W    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int DY_W    = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = COL_W + ROW_W + COLOR_DEPTH;

    typedef enum logic [2:0] {INIT_WAIT, IDLE, LOAD, DRAW, CLEAR} state_t;

    state_t                 state_reg, state_next;
    logic [COL_W-1:0]       col_reg, col_next;
    logic [ROW_W-1:0]       row_reg, row_next;
    logic [DX_W-1:0]        dx_reg, dx_next;
    logic [DY_W-1:0]        dy_reg, dy_next;
    logic [COLOR_DEPTH-1:0] color_reg, color_next;
    logic [9:0]             pix_x_reg, pix_x_next;
    logic [8:0]             pix_y_reg, pix_y_next;
    logic [COLOR_DEPTH-1:0] pix_color_reg, pix_color_next;
    logic                   pix_write_reg, pix_write_next;
    logic                   done_reg, done_next;
    logic                   req_err_reg, req_err_next;
    logic                   clear_pending_reg, clear_pending_next;

    logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_reg, rd_ptr_reg;
    logic [ENTRY_W-1:0]     head;
    logic                   full, empty, in_range, push, pop;
    logic                   emit, start_clear, cell_last, grid_last;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full      = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign req_ready = !full;
    assign in_range  = (int'(req_col) < COLS) && (int'(req_row) < ROWS);
    assign push      = req_valid && !full && in_range;
    assign head      = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    assign cell_last = (dx_reg == DX_W'(CELL_W - 1)) && (dy_reg == DY_W'(CELL_H - 1));
    assign grid_last = (col_reg == COL_W'(COLS - 1)) && (row_reg == ROW_W'(ROWS - 1));

    assign busy      = (state_reg == CLEAR) || (state_reg == LOAD) || (state_reg == DRAW);
    assign pix_x     = pix_x_reg;
    assign pix_y     = pix_y_reg;
    assign pix_color = pix_color_reg;
    assign pix_write = pix_write_reg;
    assign done      = done_reg;
    assign req_err   = req_err_reg;

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {req_col, req_row, req_color};
        end
    end

    // Counters always hold the pixel currently presented on pix_*; emit registers the next one.
    always_comb begin
        state_next         = state_reg;
        col_next           = col_reg;
        row_next           = row_reg;
        dx_next            = dx_reg;
        dy_next            = dy_reg;
        color_next         = color_reg;
        clear_pending_next = clear_pending_reg;
        pix_x_next         = pix_x_reg;
        pix_y_next         = pix_y_reg;
        pix_color_next     = pix_color_reg;
        pix_write_next     = 1'b0;
        done_next          = 1'b0;
        req_err_next       = req_valid && !full && !in_range;
        pop                = 1'b0;
        emit               = 1'b0;
        start_clear        = 1'b0;

        if (clear_req && (state_reg != IDLE) && (state_reg != CLEAR)) begin
            clear_pending_next = 1'b1;
        end

        case (state_reg)
            INIT_WAIT: start_clear = vga_sync;
            IDLE: begin
                if (clear_pending_reg || clear_req) begin
                    start_clear = 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                    state_next = LOAD;
                    {col_next, row_next, color_next} = head;
                    dx_next = '0;
                    dy_next = '0;
                end
            end
            LOAD: begin
                state_next = DRAW;
                emit = 1'b1;
            end
            DRAW, CLEAR: begin
                if (cell_last && (state_reg == DRAW || grid_last)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    emit = 1'b1;
                    if (dx_reg == DX_W'(CELL_W - 1)) begin
                        dx_next = '0;
                        dy_next = (dy_reg == DY_W'(CELL_H - 1)) ? '0 : dy_reg + 1'b1;
                    end else begin
                        dx_next = dx_reg + 1'b1;
                    end
                    if (cell_last) begin
                        if (col_reg == COL_W'(COLS - 1)) begin
                            col_next = '0;
                            row_next = row_reg + 1'b1;
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = INIT_WAIT;
        endcase

        if (start_clear) begin
            state_next         = CLEAR;
            col_next           = '0;
            row_next           = '0;
            dx_next            = '0;
            dy_next            = '0;
            color_next         = BG_COLOR;
            clear_pending_next = 1'b0;
            emit               = 1'b1;
        end

        if (emit) begin
            pix_write_next = 1'b1;
            pix_x_next     = 10'(X0 + int'(col_next) * PITCH_X + int'(dx_next));
            pix_y_next     = 9'(Y0 + int'(row_next) * PITCH_Y + int'(dy_next));
            pix_color_next = color_next;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_reg         <= INIT_WAIT;
            col_reg           <= '0;
            row_reg           <= '0;
            dx_reg            <= '0;
            dy_reg            <= '0;
            color_reg         <= BG_COLOR;
            pix_x_reg         <= 10'(X0);
            pix_y_reg         <= 9'(Y0);
            pix_color_reg     <= BG_COLOR;
            pix_write_reg     <= 1'b0;
            done_reg          <= 1'b0;
            req_err_reg       <= 1'b0;
            clear_pending_reg <= 1'b0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
        end else begin
            state_reg         <= state_next;
            col_reg           <= col_next;
            row_reg           <= row_next;
            dx_reg            <= dx_next;
            dy_reg            <= dy_next;
            color_reg         <= color_next;
            pix_x_reg         <= pix_x_next;
            pix_y_reg         <= pix_y_next;
            pix_color_reg     <= pix_color_next;
            pix_write_reg     <= pix_write_next;
            done_reg          <= done_next;
            req_err_reg       <= req_err_next;
            clear_pending_reg <= clear_pending_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_grid_renderer.sv
// Bench for vga_grid_renderer on a reduced grid: a job-level reference model feeds a pixel
// scoreboard that a negedge monitor drains against the DUT write stream.
module tb_vga_grid_renderer;
    localparam int COLS = 5, ROWS = 3, CELL_W = 4, CELL_H = 3, PX = 6, PY = 5;
    localparam int X0 = 214, Y0 = 32, CD = 9, BG = 7, FD = 4;
    localparam int CW = 3, RW = 2;
    localparam int LIMIT = 3000;

    logic          CLOCK_50 = 1'b0;
    logic          Reset, vga_sync, clear_req, req_valid, req_ready;
    logic [CW-1:0] req_col;
    logic [RW-1:0] req_row;
    logic [CD-1:0] req_color;
    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic [CD-1:0] pix_color;
    logic          pix_write, busy, done, req_err;

    typedef struct {bit is_clear; int col; int row; int color;} job_t;
    typedef struct {int x; int y; int c;} pix_t;

    job_t job_q[$];
    pix_t pix_q[$];
    int   err_cyc_q[$];
    int   checks = 0, errors = 0, cyc = 0, job_idx = 0;
    bit   cur_clear = 1'b0, done_exp = 1'b0;

    vga_grid_renderer #(
        .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .PITCH_X(PX), .PITCH_Y(PY), .X0(X0), .Y0(Y0), .COLOR_DEPTH(CD),
        .BG_COLOR(CD'(BG)), .FIFO_DEPTH(FD)
    ) dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .vga_sync(vga_sync), .clear_req(clear_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_col(req_col), .req_row(req_row),
        .req_color(req_color), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_write(pix_write), .busy(busy), .done(done), .req_err(req_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_job(input bit is_clear, input int c, input int r, input int color,
                            input bit front);
        job_t j;
        j.is_clear = is_clear; j.col = c; j.row = r; j.color = color;
        if (front) job_q.push_front(j);
        else       job_q.push_back(j);
    endtask

    // Caller is aligned just after a rising edge; returns just after the accepting edge.
    task automatic send(input int c, input int r, input int color, output int stalls);
        stalls    = 0;
        req_col   = c[CW-1:0];
        req_row   = r[RW-1:0];
        req_color = color[CD-1:0];
        req_valid = 1'b1;
        forever begin
            @(negedge CLOCK_50);
            if (req_ready) break;
            stalls++;
            if (stalls > LIMIT) break;
        end
        chk("accept_timeout", int'(stalls <= LIMIT), 1);
        step();
        req_valid = 1'b0;
        $display("req col=%0d row=%0d color=%03h stalls=%0d", c, r, color, stalls);
        if (c >= COLS || r >= ROWS) err_cyc_q.push_back(cyc);
        else push_job(1'b0, c, r, color, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pix_q.size() != 0 || job_q.size() != 0 || busy) && n < LIMIT) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("idle_timeout", int'(n < LIMIT), 1);
        step();
    endtask

    task automatic wait_px(input bit want_clear, input int idx);
        int n = 0;
        while (!(cur_clear == want_clear && job_idx == idx) && n < LIMIT) begin
            @(posedge CLOCK_50);
            n++;
        end
        chk("reach_pixel", int'(n < LIMIT), 1);
        #1;
    endtask

    // Monitor: expands model jobs into pixels and checks stream, gaps, done and req_err.
    initial begin
        job_t j;
        pix_t p;
        bit   err_e;
        forever begin
            @(negedge CLOCK_50);
            if (Reset) begin
                pix_q.delete();
                job_q.delete();
                err_cyc_q.delete();
                done_exp = 1'b0;
            end else begin
                err_e = (err_cyc_q.size() > 0) && (err_cyc_q[0] == cyc);
                if (err_e) void'(err_cyc_q.pop_front());
                chk("req_err", int'(req_err), int'(err_e));
                chk("done", int'(done), int'(done_exp));
                done_exp = 1'b0;
                if (pix_q.size() > 0) chk("no_gap_write", int'(pix_write), 1);
                if (pix_write && pix_q.size() == 0) begin
                    if (job_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=(%0d,%0d) required=no write",
                                 pix_x, pix_y);
                    end else begin
                        j = job_q.pop_front();
                        cur_clear = j.is_clear;
                        job_idx = 0;
                        for (int r = 0; r < ROWS; r++)
                            for (int c = 0; c < COLS; c++)
                                for (int dy = 0; dy < CELL_H; dy++)
                                    for (int dx = 0; dx < CELL_W; dx++)
                                        if (j.is_clear || (r == j.row && c == j.col)) begin
                                            p.x = X0 + c * PX + dx;
                                            p.y = Y0 + r * PY + dy;
                                            p.c = j.is_clear ? BG : j.color;
                                            pix_q.push_back(p);
                                        end
                        $display("job start clear=%0d col=%0d row=%0d pixels=%0d",
                                 j.is_clear, j.col, j.row, pix_q.size());
                    end
                end
                if (pix_write && pix_q.size() > 0) begin
                    p = pix_q.pop_front();
                    chk("pix_x", int'(pix_x), p.x);
                    chk("pix_y", int'(pix_y), p.y);
                    chk("pix_color", int'(pix_color), p.c);
                    job_idx++;
                    if (pix_q.size() == 0) done_exp = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int st [6];
        int s0, g;
        Reset = 1'b1; vga_sync = 1'b0; clear_req = 1'b0; req_valid = 1'b0;
        req_col = '0; req_row = '0; req_color = '0;

        // Reset state, then initial clear with an absorbed clear_req mid-clear
        repeat (3) @(negedge CLOCK_50);
        chk("rst_pix_write", int'(pix_write), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_req_err", int'(req_err), 0);
        chk("rst_pix_x", int'(pix_x), X0);
        chk("rst_pix_y", int'(pix_y), Y0);
        chk("rst_pix_color", int'(pix_color), BG);
        chk("rst_req_ready", int'(req_ready), 1);
        repeat (7) @(posedge CLOCK_50);
        #1 Reset = 1'b0;
        repeat (5) step();
        chk("init_wait_busy", int'(busy), 0);
        vga_sync = 1'b1;
        push_job(1'b1, 0, 0, BG, 1'b0);
        wait_px(1'b1, 50);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_idle();

        // Single cell: first write two edges after acceptance
        send(3, 2, 'h1FF, s0);
        @(negedge CLOCK_50);
        chk("lat_idle_write", int'(pix_write), 0);
        @(negedge CLOCK_50);
        chk("lat_load_write", int'(pix_write), 0);
        chk("lat_load_busy", int'(busy), 1);
        @(negedge CLOCK_50);
        chk("lat_first_write", int'(pix_write), 1);
        wait_idle();

        // FIFO fills while a cell draws
        send(0, 0, 'h0AA, s0);
        step();
        step();
        for (int i = 0; i < 6; i++) send(i % COLS, (i + 1) % ROWS, 16 * i + 3, st[i]);
        for (int i = 0; i < FD; i++) chk("fifo_no_stall", st[i], 0);
        chk("ready_drops_when_full", int'(st[FD] > 0), 1);
        wait_idle();

        // Out-of-range requests are dropped
        send(5, 0, 'h055, s0);
        send(0, 3, 'h066, s0);
        repeat (6) step();
        chk("bad_req_busy", int'(busy), 0);
        chk("bad_req_ready", int'(req_ready), 1);

        // clear_req mid-cell with two queued cells
        send(1, 1, 'h111, s0);
        send(2, 0, 'h022, s0);
        send(4, 2, 'h150, s0);
        wait_px(1'b0, 5);
        clear_req = 1'b1;
        push_job(1'b1, 0, 0, BG, 1'b1);
        step();
        clear_req = 1'b0;
        wait_idle();

        // Reset mid-cell with three queued cells
        vga_sync = 1'b0;
        send(0, 1, 'h0F0, s0);
        send(1, 2, 'h00F, s0);
        send(2, 1, 'h1E0, s0);
        send(3, 0, 'h101, s0);
        wait_px(1'b0, 5);
        #1 Reset = 1'b1;
        #1;
        chk("abort_pix_write", int'(pix_write), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_req_ready", int'(req_ready), 1);
        repeat (3) @(posedge CLOCK_50);
        #1 Reset = 1'b0;
        repeat (10) step();
        chk("post_rst_busy", int'(busy), 0);
        vga_sync = 1'b1;
        push_job(1'b1, 0, 0, BG, 1'b0);
        wait_idle();
        repeat (20) step();
        chk("post_clear_busy", int'(busy), 0);

        // Randomised requests, some out of range
        for (int i = 0; i < 30; i++) begin
            g = int'($urandom_range(0, 12));
            if (g > 0) repeat (g) step();
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 511)), s0);
        end
        wait_idle();
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
